// File: rtl/charram_dram_pkg.sv
// Shared types and geometry for the 4416-style character DRAM controller.
package charram_dram_pkg;

    localparam int ROW_W  = 8;
    localparam int COL_W  = 6;
    localparam int DATA_W = 4;
    localparam int ADDR_W = ROW_W + COL_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW,
        ST_COL,
        ST_ACC,
        ST_RFSH,
        ST_PRE
    } state_t;

    // Column goes out on the middle six pins of the multiplexed bus.
    function automatic logic [ROW_W-1:0] col_addr(input logic [COL_W-1:0] col);
        return {1'b0, col, 1'b0};
    endfunction

endpackage

// File: rtl/charram_dram_ctrl_rfsh_timer.sv
// Refresh interval counter with a single-deep pending flag and
// a sticky overrun flag for refreshes that could not be queued.
module charram_rfsh_timer #(
    parameter int EN       = 1,
    parameter int INTERVAL = 128
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic pending,
    output logic overrun
);

    localparam int CNT_W = $clog2(INTERVAL);

    logic [CNT_W-1:0] cnt;
    logic             tc;

    assign tc = (EN != 0) && (cnt == CNT_W'(INTERVAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (EN != 0) begin
                cnt <= tc ? '0 : cnt + 1'b1;
            end
            // A fresh terminal count wins over the FSM taking the old one.
            if (tc) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
            if (tc && pending && !clr) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/charram_dram_ctrl.sv
// Single-nibble req/ack front end for one 16k x 4 charram plane:
// row/column strobe sequencing plus RAS-only refresh.
module charram_dram_ctrl
    import charram_dram_pkg::*;
#(
    parameter int PRECHARGE_CYCLES   = 1,
    parameter int REFRESH_EN         = 1,
    parameter int REFRESH_INTERVAL   = 128,
    parameter int REFRESH_RAS_CYCLES = 2
) (
    input  logic              i_MCLK,
    input  logic              i_RST_n,
    input  logic              i_REQ,
    input  logic              i_WE,
    input  logic [ADDR_W-1:0] i_ADDR,
    input  logic [DATA_W-1:0] i_WDATA,
    output logic [DATA_W-1:0] o_RDATA,
    output logic              o_ACK,
    output logic              o_BUSY,
    output logic [ROW_W-1:0]  o_DRAM_ADDR,
    output logic [DATA_W-1:0] o_DRAM_DOUT,
    input  logic [DATA_W-1:0] i_DRAM_DIN,
    output logic              o_RAS_n,
    output logic              o_CAS_n,
    output logic              o_WR_n,
    output logic              o_RD_n,
    output logic              o_RFSH_OVERRUN
);

    localparam int MAXC  = (PRECHARGE_CYCLES > REFRESH_RAS_CYCLES) ?
                           PRECHARGE_CYCLES : REFRESH_RAS_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [COL_W-1:0]   col_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               we_q;
    logic               is_rfsh;
    logic [ROW_W-1:0]   rrow;
    logic               pending;
    logic               clr;
    logic               accept;
    logic               ack_nx;
    logic               rd_cap;
    logic               rrow_inc;
    logic               ras_nx, cas_nx, wr_nx, rd_nx;
    logic [ROW_W-1:0]   addr_nx;
    logic [DATA_W-1:0]  dout_nx;

    charram_rfsh_timer #(
        .EN       (REFRESH_EN),
        .INTERVAL (REFRESH_INTERVAL)
    ) u_rfsh_timer (
        .clk     (i_MCLK),
        .rst_n   (i_RST_n),
        .clr     (clr),
        .pending (pending),
        .overrun (o_RFSH_OVERRUN)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clr      = 1'b0;
        accept   = 1'b0;
        ack_nx   = 1'b0;
        rd_cap   = 1'b0;
        rrow_inc = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pending) begin
                    clr      = 1'b1;
                    cnt_nx   = '0;
                    state_nx = ST_RFSH;
                end else if (i_REQ && !o_ACK) begin
                    accept   = 1'b1;
                    state_nx = ST_ROW;
                end
            end
            ST_ROW: state_nx = ST_COL;
            ST_COL: state_nx = ST_ACC;
            ST_ACC: begin
                cnt_nx   = '0;
                state_nx = ST_PRE;
            end
            ST_RFSH: begin
                if (cnt == CNT_W'(REFRESH_RAS_CYCLES - 1)) begin
                    cnt_nx   = '0;
                    rrow_inc = 1'b1;
                    state_nx = ST_PRE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_PRE: begin
                if (cnt == '0 && !is_rfsh) begin
                    ack_nx = 1'b1;
                    rd_cap = !we_q;
                end
                if (cnt == CNT_W'(PRECHARGE_CYCLES - 1)) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Pin values for the state being entered, so every pin is a flop.
    always_comb begin
        ras_nx  = !(state_nx inside {ST_ROW, ST_COL, ST_ACC, ST_RFSH});
        cas_nx  = !(state_nx inside {ST_COL, ST_ACC});
        wr_nx   = !(state_nx == ST_ACC && we_q);
        rd_nx   = !(state_nx == ST_ACC && !we_q);
        dout_nx = (state_nx == ST_ACC && we_q) ? wdata_q : o_DRAM_DOUT;
        unique case (state_nx)
            ST_ROW:  addr_nx = i_ADDR[ROW_W-1:0];
            ST_COL:  addr_nx = col_addr(col_q);
            ST_RFSH: addr_nx = rrow;
            default: addr_nx = o_DRAM_ADDR;
        endcase
    end

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            col_q       <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            is_rfsh     <= 1'b0;
            rrow        <= '0;
            o_ACK       <= 1'b0;
            o_RDATA     <= '0;
            o_DRAM_ADDR <= '0;
            o_DRAM_DOUT <= '0;
            o_RAS_n     <= 1'b1;
            o_CAS_n     <= 1'b1;
            o_WR_n      <= 1'b1;
            o_RD_n      <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                col_q   <= i_ADDR[ADDR_W-1:ROW_W];
                wdata_q <= i_WDATA;
                we_q    <= i_WE;
                is_rfsh <= 1'b0;
            end else if (clr) begin
                is_rfsh <= 1'b1;
            end
            rrow        <= rrow + {{(ROW_W-1){1'b0}}, rrow_inc};
            o_ACK       <= ack_nx;
            if (rd_cap) begin
                o_RDATA <= i_DRAM_DIN;
            end
            o_DRAM_ADDR <= addr_nx;
            o_DRAM_DOUT <= dout_nx;
            o_RAS_n     <= ras_nx;
            o_CAS_n     <= cas_nx;
            o_WR_n      <= wr_nx;
            o_RD_n      <= rd_nx;
        end
    end

    assign o_BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_charram_dram_ctrl.sv
// Bench for charram_dram_ctrl: three instances (no refresh, 16-cycle
// refresh, 2-cycle refresh) each driving a behavioural 16k x 4 DRAM.
module tb_charram_dram_ctrl;

    localparam int RAS_W = 2;
    localparam int PRE_W = 1;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;

    logic        req_a, we_a, req_b, we_b;
    logic [13:0] addr_a, addr_b;
    logic [3:0]  wdata_a, wdata_b, rdata_a, rdata_b, rdata_c;
    logic        ack_a, ack_b, ack_c, busy_a, busy_b, busy_c;
    logic [7:0]  daddr_a, daddr_b, daddr_c;
    logic [3:0]  dout_a, dout_b, dout_c, din_a, din_b;
    logic        ras_a, cas_a, wr_a, rd_a, ovr_a;
    logic        ras_b, cas_b, wr_b, rd_b, ovr_b;
    logic        ras_c, cas_c, wr_c, rd_c, ovr_c;

    charram_dram_ctrl #(.REFRESH_EN(0)) dut_a (
        .i_MCLK(clk), .i_RST_n(rst_n), .i_REQ(req_a), .i_WE(we_a),
        .i_ADDR(addr_a), .i_WDATA(wdata_a), .o_RDATA(rdata_a),
        .o_ACK(ack_a), .o_BUSY(busy_a), .o_DRAM_ADDR(daddr_a),
        .o_DRAM_DOUT(dout_a), .i_DRAM_DIN(din_a), .o_RAS_n(ras_a),
        .o_CAS_n(cas_a), .o_WR_n(wr_a), .o_RD_n(rd_a),
        .o_RFSH_OVERRUN(ovr_a)
    );

    charram_dram_ctrl #(.REFRESH_INTERVAL(16)) dut_b (
        .i_MCLK(clk), .i_RST_n(rst_n), .i_REQ(req_b), .i_WE(we_b),
        .i_ADDR(addr_b), .i_WDATA(wdata_b), .o_RDATA(rdata_b),
        .o_ACK(ack_b), .o_BUSY(busy_b), .o_DRAM_ADDR(daddr_b),
        .o_DRAM_DOUT(dout_b), .i_DRAM_DIN(din_b), .o_RAS_n(ras_b),
        .o_CAS_n(cas_b), .o_WR_n(wr_b), .o_RD_n(rd_b),
        .o_RFSH_OVERRUN(ovr_b)
    );

    charram_dram_ctrl #(.REFRESH_INTERVAL(2), .REFRESH_RAS_CYCLES(2)) dut_c (
        .i_MCLK(clk), .i_RST_n(rst_n), .i_REQ(1'b0), .i_WE(1'b0),
        .i_ADDR(14'd0), .i_WDATA(4'd0), .o_RDATA(rdata_c),
        .o_ACK(ack_c), .o_BUSY(busy_c), .o_DRAM_ADDR(daddr_c),
        .o_DRAM_DOUT(dout_c), .i_DRAM_DIN(4'd0), .o_RAS_n(ras_c),
        .o_CAS_n(cas_c), .o_WR_n(wr_c), .o_RD_n(rd_c),
        .o_RFSH_OVERRUN(ovr_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 4416 planes: row on RAS-only cycles, column while CAS low,
    // write/read on the clock edge that sees WR_n/RD_n low; DOUT registered.
    logic [3:0] mem_a [16384];
    logic [3:0] mem_b [16384];
    logic [7:0] row_a, row_b;
    logic [5:0] col_a, col_b;

    always @(posedge clk) begin
        if (!ras_a && cas_a) row_a <= daddr_a;
        if (!cas_a) col_a <= daddr_a[6:1];
        if (!wr_a) mem_a[{col_a, row_a}] <= dout_a;
        if (!rd_a) din_a <= mem_a[{col_a, row_a}];
        if (!ras_b && cas_b) row_b <= daddr_b;
        if (!cas_b) col_b <= daddr_b[6:1];
        if (!wr_b) mem_b[{col_b, row_b}] <= dout_b;
        if (!rd_b) din_b <= mem_b[{col_b, row_b}];
    end

    // Observation counters and refresh history.
    int ack_cnt_a = 0;
    int wr_cnt_a = 0;
    int rd_cnt_a = 0;
    int bad_a = 0;
    int bad_b = 0;
    bit idle_b = 1'b1;
    logic prev_ras_b = 1'b1;
    logic prev_ras_c = 1'b1;
    int start_b = 0;
    int rf_cyc_b[$];
    logic [7:0] rf_row_b[$];
    int rf_len_b[$];
    int first_rf_c = -1;
    int ovr_rise_c = -1;
    int ovr_drop_c = 0;

    always @(negedge clk) begin
        if (ack_a) ack_cnt_a <= ack_cnt_a + 1;
        if (!wr_a) wr_cnt_a <= wr_cnt_a + 1;
        if (!rd_a) rd_cnt_a <= rd_cnt_a + 1;
        if ((!wr_a || !rd_a) && (ras_a || cas_a || (!wr_a && !rd_a)))
            bad_a <= bad_a + 1;
        if (idle_b && (!cas_b || !wr_b || !rd_b)) bad_b <= bad_b + 1;
        prev_ras_b <= ras_b;
        if (!ras_b && prev_ras_b) begin
            start_b <= cyc;
            rf_cyc_b.push_back(cyc);
            rf_row_b.push_back(daddr_b);
        end
        if (ras_b && !prev_ras_b) rf_len_b.push_back(cyc - start_b);
        prev_ras_c <= ras_c;
        if (!ras_c && prev_ras_c && first_rf_c < 0) first_rf_c <= cyc;
        if (ovr_c && ovr_rise_c < 0) ovr_rise_c <= cyc;
        if (ovr_rise_c >= 0 && !ovr_c && rst_n) ovr_drop_c <= ovr_drop_c + 1;
    end

    logic [3:0]  ref_a [16384];
    logic [13:0] written[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic access_a(input logic we, input logic [13:0] a,
                            input logic [3:0] d, input bit detail);
        int n;
        int wr0, rd0, ack0;
        logic [7:0] ca;
        ca = {1'b0, a[13:8], 1'b0};
        wr0 = wr_cnt_a;
        rd0 = rd_cnt_a;
        ack0 = ack_cnt_a;
        req_a = 1'b1; we_a = we; addr_a = a; wdata_a = d;
        n = 0;
        do begin
            step();
            n++;
            if (detail) begin
                if (n == 1) begin
                    chk("row_pins", {ras_a, cas_a, wr_a, rd_a}, 4'b0111);
                    chk("row_addr", daddr_a, a[7:0]);
                end
                if (n == 2) begin
                    chk("col_pins", {ras_a, cas_a, wr_a, rd_a}, 4'b0011);
                    chk("col_addr", daddr_a, ca);
                end
                if (n == 3) begin
                    chk("acc_pins", {ras_a, cas_a, wr_a, rd_a},
                        we ? 4'b0001 : 4'b0010);
                    chk("acc_addr", daddr_a, ca);
                    if (we) chk("acc_dout", dout_a, d);
                end
                if (n == 4) chk("pre_pins", {ras_a, cas_a, wr_a, rd_a, ack_a}, 5'b11110);
            end
        end while (!ack_a && n < 20);
        chk("ack_latency_a", n, 5);
        if (!we) chk("rdata_a", rdata_a, ref_a[a]);
        step();
        req_a = 1'b0;
        step();
        step();
        chk("one_ack_a", ack_cnt_a - ack0, 1);
        chk("wr_pulses_a", wr_cnt_a - wr0, we ? 1 : 0);
        chk("rd_pulses_a", rd_cnt_a - rd0, we ? 0 : 1);
        chk("idle_after_a", busy_a, 1'b0);
        if (we) begin
            ref_a[a] = d;
            written.push_back(a);
            chk("cell_a", mem_a[a], d);
        end
    endtask

    task automatic access_b(input logic we, input logic [13:0] a,
                            input logic [3:0] d, output int n);
        req_b = 1'b1; we_b = we; addr_b = a; wdata_b = d;
        n = 0;
        do begin
            step();
            n++;
        end while (!ack_b && n < 30);
        step();
        req_b = 1'b0;
    endtask

    // Align to "off" edges after the next B refresh starts.
    task automatic sync_rf_b(input int off);
        int k, g, ls;
        k = rf_cyc_b.size();
        g = 0;
        while (rf_cyc_b.size() == k && g < 40) begin
            step();
            g++;
        end
        chk("rf_b_seen", rf_cyc_b.size() > k, 1);
        ls = rf_cyc_b[$];
        while (cyc < ls + off) step();
    endtask

    initial begin
        int g, nu, nc, br, bg, bl;
        logic we;
        logic [13:0] a, ab;
        logic [3:0] d, db;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        repeat (3) step();
        chk("rst_pins", {ras_a, cas_a, wr_a, rd_a, ack_a, busy_a}, 6'b111100);
        chk("rst_data", {rdata_a, daddr_a, dout_a}, 16'h0);
        chk("rst_ovr", {ovr_a, ovr_b, ovr_c}, 3'b000);
        rst_n = 1'b1;
        step();
        chk("ovr_c_start", ovr_c, 1'b0);

        g = 0;
        while (ovr_rise_c < 0 && g < 20) begin
            step();
            g++;
        end
        chk("ovr_c_set", ovr_c, 1'b1);
        chk("ovr_c_in_first_rfsh",
            (first_rf_c >= 0) && (ovr_rise_c - first_rf_c >= 1) &&
            (ovr_rise_c - first_rf_c <= RAS_W + PRE_W), 1);

        access_a(1'b1, 14'h2A5C, 4'hA, 1'b1);
        access_a(1'b0, 14'h2A5C, 4'h0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            we = (written.size() == 0) || ($urandom_range(0, 1) == 1);
            if (!we) a = written[$urandom_range(0, written.size() - 1)];
            else a = 14'($urandom_range(0, 16383));
            d = 4'($urandom_range(0, 15));
            access_a(we, a, d, 1'b0);
        end
        chk("wr_rd_only_in_acc", bad_a, 0);

        g = 0;
        while (rf_cyc_b.size() < 258 && g < 6000) begin
            step();
            g++;
        end
        idle_b = 1'b0;
        chk("rf_b_count", rf_cyc_b.size() >= 258, 1);
        br = 0; bg = 0; bl = 0;
        for (int i = 0; i < 258 && i < rf_cyc_b.size(); i++) begin
            if (rf_row_b[i] !== 8'(i)) br++;
            if (i > 0 && rf_cyc_b[i] - rf_cyc_b[i-1] != 16) bg++;
            if (i < rf_len_b.size() && rf_len_b[i] != RAS_W) bl++;
        end
        chk("rf_rows", br, 0);
        chk("rf_period", bg, 0);
        chk("rf_ras_width", bl, 0);
        chk("rf_row_wrap", rf_row_b[256], 8'h00);
        chk("rf_only_ras", bad_b, 0);

        ab = 14'($urandom_range(0, 16383));
        sync_rf_b(4);
        access_b(1'b1, ab, 4'($urandom_range(0, 15)), nu);
        chk("uncontended_lat_b", nu, 5);
        db = 4'($urandom_range(0, 15));
        sync_rf_b(15);
        access_b(1'b1, ab, db, nc);
        chk("contended_lat_b", nc, 9);
        chk("contended_delay", nc - nu, 4);
        chk("contended_cell", mem_b[ab], db);
        sync_rf_b(4);
        access_b(1'b0, ab, 4'h0, nu);
        chk("contended_readback", rdata_b, db);

        chk("ovr_c_sticky", {ovr_c, 1'b0}, 2'b10);
        chk("ovr_c_no_drop", ovr_drop_c, 0);

        // Pull reset in the middle of a write's ACC cycle.
        a = 14'h2A5C;
        g = ack_cnt_a;
        req_a = 1'b1; we_a = 1'b1; addr_a = a; wdata_a = ~ref_a[a];
        repeat (3) step();
        chk("abort_in_acc", {ras_a, cas_a, wr_a}, 3'b000);
        rst_n = 1'b0;
        #1;
        chk("abort_pins", {ras_a, cas_a, wr_a, rd_a, busy_a}, 5'b11110);
        chk("abort_ovr_clr", ovr_c, 1'b0);
        req_a = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("abort_no_ack", ack_cnt_a - g, 0);
        chk("abort_cell_kept", mem_a[a], ref_a[a]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
